// File: rtl/xorshift_stream_bank.sv
// xorshift_stream_bank: NCH independent xorshift128 generators behind a
// valid/ready stream. Channels are served round-robin, one word per accept.
// After reset or reseed every channel is stepped WARMUP times before output.
// Optional feature macro PRNG_RANGE_EN: scales each word into [0, range)
// via the upper half of a 32x32 product (range == 0 passes the raw word).
module xorshift_stream_bank #(
  parameter int          NCH          = 4,
  parameter int          WARMUP       = 16,
  parameter logic [31:0] SEED_DEFAULT = 32'd88675123
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   seed_valid,
  output logic                                   seed_ready,
  input  logic [31:0]                            seed,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [31:0]                            out_data,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] out_ch,
  output logic                                   busy,
  input  logic [31:0]                            range
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [15:0] LAST = (WARMUP > 0) ? 16'(WARMUP - 1) : 16'd0;

  typedef enum logic {WARM, RUN} state_t;
  localparam state_t START = (WARMUP > 0) ? WARM : RUN;

  state_t          state, state_nxt;
  logic [15:0]     cnt;
  logic [PW-1:0]   ptr;
  logic            load_req, warm_step, run_step;

  logic [31:0] xs [NCH];
  logic [31:0] ys [NCH];
  logic [31:0] zs [NCH];
  logic [31:0] ws [NCH];
  logic [31:0] w_sel;

  // Per-channel initial w: seed decorrelated by a golden-ratio multiple of k.
  function automatic logic [31:0] chan_seed(input int k, input logic [31:0] s);
    logic [31:0] kk;
    kk = 32'(k);
    return s ^ (kk * 32'h9E3779B9);
  endfunction

  // New w word of one xorshift128 step.
  function automatic logic [31:0] next_w(input logic [31:0] x, input logic [31:0] w);
    logic [31:0] t;
    t = x ^ (x << 11);
    return w ^ (w >> 19) ^ t ^ (t >> 8);
  endfunction

  // Next-state decode: warm-up runs unconditionally, RUN steps on accept
  // and a reseed in RUN takes priority over the step.
  always_comb begin
    state_nxt = state;
    load_req  = 1'b0;
    warm_step = 1'b0;
    run_step  = 1'b0;
    case (state)
      WARM: begin
        warm_step = 1'b1;
        if (cnt == LAST) state_nxt = RUN;
      end
      RUN: begin
        if (seed_valid) begin
          load_req  = 1'b1;
          state_nxt = START;
        end else if (out_ready) begin
          run_step = 1'b1;
        end
      end
      default: state_nxt = START;
    endcase
  end

  // Control registers: state, warm-up counter and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= START;
      cnt   <= 16'd0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (load_req) begin
        cnt <= 16'd0;
        ptr <= '0;
      end else begin
        if (warm_step) cnt <= cnt + 16'd1;
        if (run_step)  ptr <= (ptr == PW'(NCH - 1)) ? '0 : ptr + 1'b1;
      end
    end
  end

  // Generator state: reload on reset/reseed, else step all (warm) or the served channel.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NCH; k++) begin
      if (rst || load_req) begin
        xs[k] <= 32'd123456789;
        ys[k] <= 32'd362436069;
        zs[k] <= 32'd521288629;
        ws[k] <= chan_seed(k, rst ? SEED_DEFAULT : seed);
      end else if (warm_step || (run_step && (ptr == PW'(k)))) begin
        xs[k] <= ys[k];
        ys[k] <= zs[k];
        zs[k] <= ws[k];
        ws[k] <= next_w(xs[k], ws[k]);
      end
    end
  end

  assign w_sel      = ws[ptr];
  assign out_valid  = (state == RUN);
  assign seed_ready = (state == RUN);
  assign busy       = (state == WARM);
  assign out_ch     = ptr;

`ifdef PRNG_RANGE_EN
  logic [63:0] prod;
  logic        unused_prod_lo;
  assign prod           = {32'd0, w_sel} * {32'd0, range};
  assign unused_prod_lo = ^prod[31:0];
  assign out_data       = (range == 32'd0) ? w_sel : prod[63:32];
`else
  logic unused_range;
  assign unused_range = ^range;
  assign out_data     = w_sel;
`endif

endmodule
